tl_latency_monitor: RTL and testbench

TL_LATENCY_MONITOR -- requirements
Module: tl_latency_monitor

---
 rtl/tl_mon_pkg.sv | 37 +++
 rtl/tl_outstanding_table.sv | 68 ++++++
 rtl/tl_latency_monitor.sv | 196 +++++++++++++++++++
 tb/tb_tl_latency_monitor.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_mon_pkg.sv
// Shared definitions for the TileLink latency monitor: A/D channel opcode
// encodings and the per-source outstanding-table entry layout.
// Latency: n/a (types only). Backpressure: n/a.
package tl_mon_pkg;

    // A-channel opcodes
    typedef enum logic [2:0] {
        A_PUT_FULL_DATA    = 3'd0,
        A_PUT_PARTIAL_DATA = 3'd1,
        A_ARITHMETIC_DATA  = 3'd2,
        A_LOGICAL_DATA     = 3'd3,
        A_GET              = 3'd4,
        A_INTENT           = 3'd5,
        A_ACQUIRE_BLOCK    = 3'd6,
        A_ACQUIRE_PERM     = 3'd7
    } a_opcode_e;

    // D-channel opcodes
    typedef enum logic [2:0] {
        D_ACCESS_ACK      = 3'd0,
        D_ACCESS_ACK_DATA = 3'd1,
        D_HINT_ACK        = 3'd2,
        D_GRANT           = 3'd4,
        D_GRANT_DATA      = 3'd5,
        D_RELEASE_ACK     = 3'd6
    } d_opcode_e;

    // Widest timestamp an entry can carry; the monitor's CNT_W must not
    // exceed it. Narrower counters store zero-extended stamps.
    localparam int TS_MAX_W = 32;

    typedef struct packed {
        logic                vld;
        logic [TS_MAX_W-1:0] ts;
    } tbl_entry_t;

endpackage

// File: rtl/tl_outstanding_table.sv
// Per-source valid/timestamp table with one allocate, one retire and one scan port.
// Latency: reads are combinational, updates land on the next clock edge.
// Backpressure: none; every enabled allocate/retire is accepted the same cycle.
//
// Ports: clock/reset (async active-high); alloc_en/idx/ts + alloc_hit (entry
// already valid); retire_en/idx + retire_hit/retire_ts; scan_idx ->
// scan_vld/scan_ts; outstanding = live entry count.
// A retire and an allocate to the same index in one cycle behave as retire
// first, then allocate.
module tl_outstanding_table
    import tl_mon_pkg::*;
#(
    parameter int SRC_W = 2,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_en,
    input  logic [SRC_W-1:0] alloc_idx,
    input  logic [CNT_W-1:0] alloc_ts,
    output logic             alloc_hit,
    input  logic             retire_en,
    input  logic [SRC_W-1:0] retire_idx,
    output logic             retire_hit,
    output logic [CNT_W-1:0] retire_ts,
    input  logic [SRC_W-1:0] scan_idx,
    output logic             scan_vld,
    output logic [CNT_W-1:0] scan_ts,
    output logic [SRC_W:0]   outstanding
);

    localparam int DEPTH = 1 << SRC_W;
    localparam int OW    = SRC_W + 1;

    tbl_entry_t tbl [DEPTH];
    logic       alloc_new;

    assign alloc_hit  = tbl[alloc_idx].vld;
    assign retire_hit = retire_en && tbl[retire_idx].vld;
    assign retire_ts  = CNT_W'(tbl[retire_idx].ts);
    assign scan_vld   = tbl[scan_idx].vld;
    assign scan_ts    = CNT_W'(tbl[scan_idx].ts);

    // An allocate only adds a live entry if the slot is free after this
    // cycle's retire (same-index retire frees it first).
    assign alloc_new = alloc_en &&
                       !(alloc_hit && !(retire_hit && (retire_idx == alloc_idx)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
            outstanding <= '0;
        end else begin
            if (retire_hit) begin
                tbl[retire_idx].vld <= 1'b0;
            end
            // Later assignment wins, so allocate overrides a same-index retire.
            if (alloc_en) begin
                tbl[alloc_idx].vld <= 1'b1;
                tbl[alloc_idx].ts  <= TS_MAX_W'(alloc_ts);
            end
            outstanding <= outstanding + OW'(alloc_new) - OW'(retire_hit);
        end
    end

endmodule

// File: rtl/tl_latency_monitor.sv
// TileLink A->D latency monitor: per-source timestamps, latency stats, sticky protocol errors.
// Latency: stats/lat_valid update one cycle after the retiring D fire; errors one cycle after the event.
// Backpressure: passive observer; never stalls either channel, only counts fires.
//
// Ports: clock, reset (async active-high), hartid (log tag), clear (sync stats
// clear); A channel a_valid/a_ready/a_opcode/a_source/a_address; D channel
// d_valid/d_ready/d_opcode/d_source/d_denied/d_corrupt; outputs outstanding,
// lat_valid, last_latency, max_latency, txn_count, denied_count, orphan_err,
// dup_err, timeout_err, timeout_src.
// Optional build macro TL_LATENCY_MONITOR_LOG_EN adds simulation logging of
// fires and first error occurrences; register behaviour is identical either way.
module tl_latency_monitor
    import tl_mon_pkg::*;
#(
    parameter int SRC_W   = 2,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        hartid,
    input  logic              clear,
    input  logic              a_valid,
    input  logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [SRC_W-1:0]  a_source,
    input  logic [ADDR_W-1:0] a_address,
    input  logic              d_valid,
    input  logic              d_ready,
    input  logic [2:0]        d_opcode,
    input  logic [SRC_W-1:0]  d_source,
    input  logic              d_denied,
    input  logic              d_corrupt,
    output logic [SRC_W:0]    outstanding,
    output logic              lat_valid,
    output logic [CNT_W-1:0]  last_latency,
    output logic [CNT_W-1:0]  max_latency,
    output logic [CNT_W-1:0]  txn_count,
    output logic [CNT_W-1:0]  denied_count,
    output logic              orphan_err,
    output logic              dup_err,
    output logic              timeout_err,
    output logic [SRC_W-1:0]  timeout_src
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cycle_cnt;
    logic [SRC_W-1:0] scan_ptr;

    logic             a_fire;
    logic             d_fire;
    logic             alloc_hit;
    logic             retire_hit;
    logic [CNT_W-1:0] retire_ts;
    logic             scan_vld;
    logic [CNT_W-1:0] scan_ts;
    logic [CNT_W-1:0] latency;
    logic [CNT_W-1:0] scan_age;
    logic             orphan_evt;
    logic             dup_evt;
    logic             denied_evt;
    logic             timeout_evt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign a_fire = a_valid && a_ready;
    // ReleaseAck answers a C-channel Release, not an A request: ignore it.
    assign d_fire = d_valid && d_ready && (d_opcode != D_RELEASE_ACK);

    tl_outstanding_table #(
        .SRC_W (SRC_W),
        .CNT_W (CNT_W)
    ) u_table (
        .clock       (clock),
        .reset       (reset),
        .alloc_en    (a_fire),
        .alloc_idx   (a_source),
        .alloc_ts    (cycle_cnt),
        .alloc_hit   (alloc_hit),
        .retire_en   (d_fire),
        .retire_idx  (d_source),
        .retire_hit  (retire_hit),
        .retire_ts   (retire_ts),
        .scan_idx    (scan_ptr),
        .scan_vld    (scan_vld),
        .scan_ts     (scan_ts),
        .outstanding (outstanding)
    );

    // Modular differences stay correct across counter wrap; an entry older
    // than 2^CNT_W cycles aliases to a younger age.
    assign latency  = cycle_cnt - retire_ts;
    assign scan_age = cycle_cnt - scan_ts;

    assign orphan_evt  = d_fire && !retire_hit;
    // Same-source A+D retires first, so the re-allocation is not a duplicate.
    assign dup_evt     = a_fire && alloc_hit && !(d_fire && (d_source == a_source));
    assign denied_evt  = d_fire && (d_denied || d_corrupt);
    assign timeout_evt = scan_vld && (scan_age > TIMEOUT_C);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            scan_ptr  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            scan_ptr  <= scan_ptr + SRC_W'(1);
        end
    end

    // Clear zeroes first; an event in the same cycle is then applied on top
    // of the cleared value, so it is never lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_valid    <= 1'b0;
            last_latency <= '0;
            max_latency  <= '0;
            txn_count    <= '0;
            denied_count <= '0;
            orphan_err   <= 1'b0;
            dup_err      <= 1'b0;
            timeout_err  <= 1'b0;
            timeout_src  <= '0;
        end else begin
            lat_valid <= retire_hit;
            if (clear) begin
                last_latency <= '0;
                max_latency  <= '0;
                txn_count    <= '0;
                denied_count <= '0;
                orphan_err   <= 1'b0;
                dup_err      <= 1'b0;
                timeout_err  <= 1'b0;
                timeout_src  <= '0;
            end
            if (retire_hit) begin
                last_latency <= latency;
                if (clear || (latency > max_latency)) begin
                    max_latency <= latency;
                end
                txn_count <= clear ? CNT_W'(1) : sat_inc(txn_count);
            end
            if (denied_evt) begin
                denied_count <= clear ? CNT_W'(1) : sat_inc(denied_count);
            end
            if (orphan_evt) begin
                orphan_err <= 1'b1;
            end
            if (dup_evt) begin
                dup_err <= 1'b1;
            end
            if (timeout_evt) begin
                timeout_err <= 1'b1;
                if (clear || !timeout_err) begin
                    timeout_src <= scan_ptr;
                end
            end
        end
    end

`ifdef TL_LATENCY_MONITOR_LOG_EN
    always @(posedge clock) begin
        if (!reset) begin
            if (a_fire) begin
                $display("[tl_mon h%0d] INFO A op=%0d src=%0d addr=%h",
                         hartid, a_opcode, a_source, a_address);
            end
            if (d_fire) begin
                $display("[tl_mon h%0d] INFO D op=%0d src=%0d lat=%0d",
                         hartid, d_opcode, d_source, latency);
            end
            if (orphan_evt && !orphan_err) begin
                $display("[tl_mon h%0d] ERROR orphan D src=%0d", hartid, d_source);
            end
            if (dup_evt && !dup_err) begin
                $display("[tl_mon h%0d] ERROR duplicate A src=%0d", hartid, a_source);
            end
            if (timeout_evt && !timeout_err) begin
                $display("[tl_mon h%0d] ERROR timeout src=%0d", hartid, scan_ptr);
            end
            if (d_fire && d_denied && d_corrupt) begin
                $display("[tl_mon h%0d] ERROR denied+corrupt D src=%0d", hartid, d_source);
            end
        end
    end
`else
    // Log-only inputs have no function in a non-logging build.
    logic unused_ok;
    assign unused_ok = ^{hartid, a_opcode, a_address};
`endif

endmodule

// File: tb/tb_tl_latency_monitor.sv
// Scoreboard bench for tl_latency_monitor: directed A/D sequences push the
// expected retirement record; a negedge monitor pops and compares on lat_valid.
// Static outputs (outstanding, errors) are compared inline by the stimulus.
module tb_tl_latency_monitor;

    localparam int SRC_W   = 2;
    localparam int ADDR_W  = 32;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1024;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        hartid = 2'd1;
    logic              clear = 1'b0;
    logic              a_valid = 1'b0;
    logic              a_ready = 1'b1;
    logic [2:0]        a_opcode = 3'd4;
    logic [SRC_W-1:0]  a_source = '0;
    logic [ADDR_W-1:0] a_address = '0;
    logic              d_valid = 1'b0;
    logic              d_ready = 1'b1;
    logic [2:0]        d_opcode = 3'd0;
    logic [SRC_W-1:0]  d_source = '0;
    logic              d_denied = 1'b0;
    logic              d_corrupt = 1'b0;
    logic [SRC_W:0]    outstanding;
    logic              lat_valid;
    logic [CNT_W-1:0]  last_latency;
    logic [CNT_W-1:0]  max_latency;
    logic [CNT_W-1:0]  txn_count;
    logic [CNT_W-1:0]  denied_count;
    logic              orphan_err;
    logic              dup_err;
    logic              timeout_err;
    logic [SRC_W-1:0]  timeout_src;

    tl_latency_monitor #(
        .SRC_W   (SRC_W),
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .hartid       (hartid),
        .clear        (clear),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_opcode     (a_opcode),
        .a_source     (a_source),
        .a_address    (a_address),
        .d_valid      (d_valid),
        .d_ready      (d_ready),
        .d_opcode     (d_opcode),
        .d_source     (d_source),
        .d_denied     (d_denied),
        .d_corrupt    (d_corrupt),
        .outstanding  (outstanding),
        .lat_valid    (lat_valid),
        .last_latency (last_latency),
        .max_latency  (max_latency),
        .txn_count    (txn_count),
        .denied_count (denied_count),
        .orphan_err   (orphan_err),
        .dup_err      (dup_err),
        .timeout_err  (timeout_err),
        .timeout_src  (timeout_src)
    );

    always #5 clock = ~clock;

    // Bench model of the free-running cycle counter (value during the current cycle).
    logic [15:0] tb_cyc;
    always @(posedge clock or posedge reset) begin
        if (reset) tb_cyc <= '0;
        else       tb_cyc <= tb_cyc + 16'd1;
    end

    typedef struct {
        logic [15:0] cyc;
        logic [15:0] lat;
        logic [15:0] txn;
        logic [15:0] mx;
        logic [15:0] den;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, tb_cyc);
        end
    endtask

    task automatic push(input logic [15:0] cyc, input logic [15:0] lat, input logic [15:0] txn,
                        input logic [15:0] mx, input logic [15:0] den);
        exp_t e;
        e.cyc = cyc; e.lat = lat; e.txn = txn; e.mx = mx; e.den = den;
        sb.push_back(e);
    endtask

    // Returns #1 after the edge that starts cycle c.
    task automatic wait_cycle(input logic [15:0] c);
        int n;
        n = 0;
        while (tb_cyc != c && n < 70000) begin
            @(posedge clock); #1;
            n++;
        end
        if (tb_cyc != c) begin
            checks++; errors++;
            $display("FAIL wait_cycle: reached %0d, required %0d", tb_cyc, c);
        end
    endtask

    // Present one cycle of stimulus, sampled at the end of the current cycle.
    task automatic drive(input logic av, input logic [1:0] as, input logic dv, input logic [1:0] ds,
                         input logic [2:0] dop, input logic den, input logic cor, input logic clr);
        a_valid = av; a_source = as; a_opcode = 3'd4; a_address = 32'h1000 + 32'(as);
        d_valid = dv; d_source = ds; d_opcode = dop; d_denied = den; d_corrupt = cor;
        clear = clr;
        @(posedge clock); #1;
        a_valid = 1'b0; d_valid = 1'b0; d_denied = 1'b0; d_corrupt = 1'b0; clear = 1'b0;
    endtask

    task automatic a_at(input logic [15:0] c, input logic [1:0] s);
        wait_cycle(c);
        drive(1'b1, s, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic d_at(input logic [15:0] c, input logic [1:0] s, input logic [2:0] op,
                        input logic den, input logic cor);
        wait_cycle(c);
        drive(1'b0, 2'd0, 1'b1, s, op, den, cor, 1'b0);
    endtask

    task automatic clear_at(input logic [15:0] c);
        wait_cycle(c);
        drive(1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // Scoreboard monitor: every lat_valid pulse must match the next expected retirement.
    always @(negedge clock) begin
        if (!reset && lat_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected: lat_valid=1 at cycle %0d, required no pulse", tb_cyc);
            end else begin
                mon_e = sb.pop_front();
                check("sb_cycle", tb_cyc, mon_e.cyc);
                check("sb_last_latency", last_latency, mon_e.lat);
                check("sb_txn_count", txn_count, mon_e.txn);
                check("sb_max_latency", max_latency, mon_e.mx);
                check("sb_denied_count", denied_count, mon_e.den);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, while asserted and just after release.
        #12;
        check("rst_outstanding", outstanding, 0);
        check("rst_lat_valid", lat_valid, 0);
        #10 reset = 1'b0;
        @(posedge clock); #1;
        check("rst_txn_count", txn_count, 0);
        check("rst_errors", {orphan_err, dup_err, timeout_err}, 0);
        check("rst_max_latency", max_latency, 0);

        // Basic A src1 @10, D src1 @25 -> latency 15 reported in cycle 26.
        a_at(16'd10, 2'd1);
        check("basic_outstanding_1", outstanding, 1);
        push(16'd26, 16'd15, 16'd1, 16'd15, 16'd0);
        d_at(16'd25, 2'd1, 3'd1, 1'b0, 1'b0);
        check("basic_outstanding_0", outstanding, 0);

        // Orphan D src2.
        d_at(16'd30, 2'd2, 3'd0, 1'b0, 1'b0);
        check("orphan_err", orphan_err, 1);
        check("orphan_no_lat", lat_valid, 0);
        check("orphan_txn", txn_count, 1);

        // Clear leaves the table intact.
        a_at(16'd32, 2'd0);
        clear_at(16'd33);
        check("clear_orphan", orphan_err, 0);
        check("clear_txn", txn_count, 0);
        check("clear_max", max_latency, 0);
        check("clear_outstanding", outstanding, 1);

        // Same-source A+D on a valid entry: retire (lat 8, denied) then re-allocate.
        push(16'd41, 16'd8, 16'd1, 16'd8, 16'd1);
        wait_cycle(16'd40);
        drive(1'b1, 2'd0, 1'b1, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        check("same_src_outstanding", outstanding, 1);
        check("same_src_no_err", {orphan_err, dup_err}, 0);
        push(16'd51, 16'd10, 16'd2, 16'd10, 16'd1);
        d_at(16'd50, 2'd0, 3'd0, 1'b0, 1'b0);
        check("same_src_retired", outstanding, 0);

        // Different-source A+D in one cycle.
        a_at(16'd55, 2'd1);
        push(16'd61, 16'd5, 16'd3, 16'd10, 16'd1);
        wait_cycle(16'd60);
        drive(1'b1, 2'd2, 1'b1, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        check("diff_src_outstanding", outstanding, 1);
        // ReleaseAck is ignored entirely.
        d_at(16'd62, 2'd2, 3'd6, 1'b0, 1'b0);
        check("release_ack_outstanding", outstanding, 1);
        check("release_ack_no_orphan", orphan_err, 0);
        // A without ready is not a fire.
        a_ready = 1'b0;
        a_at(16'd63, 2'd3);
        a_ready = 1'b1;
        check("a_not_ready", outstanding, 1);
        push(16'd66, 16'd5, 16'd4, 16'd10, 16'd2);
        d_at(16'd65, 2'd2, 3'd1, 1'b0, 1'b1);
        check("corrupt_outstanding", outstanding, 0);

        // Duplicate A overwrites the timestamp.
        a_at(16'd70, 2'd1);
        a_at(16'd72, 2'd1);
        check("dup_err", dup_err, 1);
        check("dup_outstanding", outstanding, 1);
        push(16'd81, 16'd8, 16'd5, 16'd10, 16'd2);
        d_at(16'd80, 2'd1, 3'd0, 1'b0, 1'b0);
        clear_at(16'd85);
        check("clear2_dup", dup_err, 0);
        check("clear2_denied", denied_count, 0);

        // Retirement coincident with clear wins over the clear.
        a_at(16'd90, 2'd0);
        push(16'd96, 16'd5, 16'd1, 16'd5, 16'd0);
        wait_cycle(16'd95);
        drive(1'b0, 2'd0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1);

        // Timeout: src3 allocated at 100; age first exceeds 1024 at 1125,
        // scanned (ptr == cycle mod 4) at 1127, flagged from 1128.
        a_at(16'd100, 2'd3);
        wait_cycle(16'd1127);
        check("timeout_not_yet", timeout_err, 0);
        wait_cycle(16'd1129);
        check("timeout_err", timeout_err, 1);
        check("timeout_src", timeout_src, 3);
        push(16'd1136, 16'd1035, 16'd2, 16'd1035, 16'd0);
        d_at(16'd1135, 2'd3, 3'd1, 1'b0, 1'b0);
        check("timeout_src_held", timeout_src, 3);
        clear_at(16'd1140);
        check("clear3_timeout", timeout_err, 0);
        check("clear3_timeout_src", timeout_src, 0);
        wait_cycle(16'd1150);
        check("no_timeout_idle", timeout_err, 0);

        // Counter wrap: stamp 0xFFF0, retire at 0x0010 -> latency 0x20.
        a_at(16'hFFF0, 2'd1);
        push(16'h0011, 16'h0020, 16'd1, 16'h0020, 16'd0);
        d_at(16'h0010, 2'd1, 3'd0, 1'b0, 1'b0);
        check("wrap_no_timeout", timeout_err, 0);

        // Reset with three entries in flight.
        a_at(16'h0020, 2'd0);
        a_at(16'h0021, 2'd1);
        a_at(16'h0022, 2'd2);
        check("pre_reset_outstanding", outstanding, 3);
        reset = 1'b1;
        #1;
        check("mid_reset_outstanding", outstanding, 0);
        check("mid_reset_txn", txn_count, 0);
        check("mid_reset_max", max_latency, 0);
        #2 reset = 1'b0;
        d_at(16'd5, 2'd1, 3'd1, 1'b0, 1'b0);
        check("post_reset_orphan", orphan_err, 1);
        check("post_reset_no_lat", lat_valid, 0);
        check("post_reset_txn", txn_count, 0);

        wait_cycle(16'd10);
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
